// File: rtl/memory_hex_scanner_if.sv
// Board-side bundle for the RAM exerciser: push-buttons, switches and six 7-segment displays.
// The design drives the displays through the slave modport; the board or a bench uses master.
interface memory_hex_scanner_if;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic [6:0] HEX3;
  logic [6:0] HEX4;
  logic [6:0] HEX5;

  modport master (output KEY, SW, input HEX0, HEX1, HEX2, HEX3, HEX4, HEX5);
  modport slave  (input KEY, SW, output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5);
endinterface

// File: rtl/memory_hex_scanner.sv
// 32x4 RAM exerciser: switch-driven writes, timed read sweep, six active-low hex displays.
// Define MEMSCAN_FAST_SIM_EN to force the step divider to 8 cycles for simulation.
module memory_hex_scanner #(
  parameter int TICK_DIV = 50_000_000
) (
  input logic            CLOCK_50,
  memory_hex_scanner_if.slave bus
);

`ifdef MEMSCAN_FAST_SIM_EN
  localparam int DIV = 8;
`else
  localparam int DIV = TICK_DIV;
`endif
  localparam int CW = $clog2(DIV);

  logic          rst_n;
  logic [3:0]    din_reg;
  logic [4:0]    waddr_reg;
  logic          wr_reg;
  logic [CW-1:0] cnt_reg;
  logic [4:0]    raddr_reg;
  logic [3:0]    q_reg;
  logic          tick;
  logic [3:0]    mem [32];
  logic [3:0]    nib [6];
  logic [6:0]    seg [6];
  logic          unused_bits;

  assign rst_n       = bus.KEY[0];
  assign unused_bits = ^{bus.KEY[2:1], bus.SW[9]};
  assign tick        = (cnt_reg == CW'(DIV - 1));

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      din_reg   <= '0;
      waddr_reg <= '0;
      wr_reg    <= 1'b0;
      cnt_reg   <= '0;
      raddr_reg <= '0;
      q_reg     <= '0;
    end else begin
      din_reg   <= bus.SW[3:0];
      waddr_reg <= bus.SW[8:4];
      wr_reg    <= ~bus.KEY[3];
      cnt_reg   <= tick ? '0 : cnt_reg + 1'b1;
      if (tick) begin
        raddr_reg <= raddr_reg + 5'd1;
      end
      // Read-before-write: a same-address write this edge is seen on the next read.
      q_reg     <= mem[raddr_reg];
    end
  end

  // wr_reg is held low by reset, so contents survive reset untouched.
  always_ff @(posedge CLOCK_50) begin
    if (wr_reg) begin
      mem[waddr_reg] <= din_reg;
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign nib[0] = q_reg;
  assign nib[1] = din_reg;
  assign nib[2] = raddr_reg[3:0];
  assign nib[3] = {3'b000, raddr_reg[4]};
  assign nib[4] = waddr_reg[3:0];
  assign nib[5] = {3'b000, waddr_reg[4]};

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_dec
      assign seg[gi] = hex7(nib[gi]);
    end
  endgenerate

  assign bus.HEX0 = seg[0];
  assign bus.HEX1 = seg[1];
  assign bus.HEX2 = seg[2];
  assign bus.HEX3 = seg[3];
  assign bus.HEX4 = seg[4];
  assign bus.HEX5 = seg[5];

endmodule

// File: tb/tb_memory_hex_scanner.sv
// Directed bench for memory_hex_scanner with an 8-cycle read step; outputs sampled on falling edges.
// Expected display codes come from the 0-F segment table and hand-derived cycle offsets.
module tb_memory_hex_scanner;
  logic clk = 1'b0;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   e      = 0;   // rising edges since the most recent reset release

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  memory_hex_scanner_if bus ();

  memory_hex_scanner #(.TICK_DIV(8)) dut (
    .CLOCK_50 (clk),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic run_to(input int target);
    while (e < target) begin
      @(negedge clk);
      e++;
    end
  endtask

  function automatic logic [6:0] sg(input int v);
    logic [3:0] n;
    n = 4'(v);
    return seg_tab[n];
  endfunction

  task automatic set_sw(input int addr, input int data, input logic wr);
    bus.SW     = {1'b0, 5'(addr), 4'(data)};
    bus.KEY[3] = ~wr;
  endtask

  task automatic reset_pulse();
    bus.KEY[0] = 1'b0;
    @(negedge clk);
    bus.KEY[0] = 1'b1;
    e = 0;
  endtask

  initial begin
    bus.KEY = 4'b1110;
    bus.SW  = 10'h3FF;
    // Reset held for three cycles with switches at all-ones: displays must still read 0.
    repeat (3) @(negedge clk);
    check("rst_hex0", bus.HEX0, 7'h40);
    check("rst_hex1", bus.HEX1, 7'h40);
    check("rst_hex2", bus.HEX2, 7'h40);
    check("rst_hex3", bus.HEX3, 7'h40);
    check("rst_hex4", bus.HEX4, 7'h40);
    check("rst_hex5", bus.HEX5, 7'h40);
    bus.SW     = '0;
    bus.KEY[0] = 1'b1;
    e = 0;

    run_to(7);
    check("hold_raddr0", bus.HEX2, 7'h40);
    run_to(8);
    check("first_step", bus.HEX2, 7'h79);

    // Write A to address 2, KEY[3] held for two cycles.
    set_sw(2, 'hA, 1'b1);
    run_to(10);
    check("wr_hex1", bus.HEX1, 7'h08);
    check("wr_hex4", bus.HEX4, 7'h24);
    check("wr_hex5", bus.HEX5, 7'h40);
    set_sw(2, 'hA, 1'b0);

    run_to(16);
    check("rb_addr2", bus.HEX2, 7'h24);
    run_to(17);
    check("rb_data", bus.HEX0, 7'h08);

    // Fill every address with its own low nibble, one address per cycle.
    for (int i = 0; i < 32; i++) begin
      set_sw(i, i, 1'b1);
      run_to(e + 1);
    end
    set_sw(0, 0, 1'b0);
    run_to(e + 2);
    check("fill_hex5", bus.HEX5, 7'h40);
    reset_pulse();

    // Full sweep: address on HEX3/HEX2 at each step, data on HEX0 one cycle later.
    for (int a = 0; a < 32; a++) begin
      run_to(8 * a);
      check($sformatf("sw_lo_%0d", a), bus.HEX2, sg(a % 16));
      check($sformatf("sw_hi_%0d", a), bus.HEX3, sg(a / 16));
      run_to(8 * a + 1);
      check($sformatf("sw_dat_%0d", a), bus.HEX0, sg(a % 16));
    end
    run_to(256);
    check("wrap_lo", bus.HEX2, 7'h40);
    check("wrap_hi", bus.HEX3, 7'h40);

    // Write 5 to address 3 on the edge that first reads address 3.
    run_to(256 + 23);
    set_sw(3, 5, 1'b1);
    run_to(256 + 24);
    set_sw(3, 5, 1'b0);
    check("rdw_addr", bus.HEX2, 7'h30);
    run_to(256 + 25);
    check("rdw_old", bus.HEX0, 7'h30);
    run_to(512 + 25);
    check("rdw_new", bus.HEX0, 7'h12);

    // Reset mid-step while the pointer sits at 0x13.
    run_to(512 + 153);
    check("pre_rst_lo", bus.HEX2, 7'h30);
    check("pre_rst_hi", bus.HEX3, 7'h79);
    bus.KEY[0] = 1'b0;
    #1;
    check("async_lo", bus.HEX2, 7'h40);
    check("async_hi", bus.HEX3, 7'h40);
    check("async_q", bus.HEX0, 7'h40);
    @(negedge clk);
    bus.KEY[0] = 1'b1;
    e = 0;
    run_to(7);
    check("post_rst_hold", bus.HEX2, 7'h40);
    run_to(17);
    check("keep_a2", bus.HEX0, 7'h24);
    run_to(25);
    check("keep_a3", bus.HEX0, 7'h12);
    run_to(153);
    check("keep_a13", bus.HEX0, 7'h30);
    run_to(249);
    check("keep_a1f", bus.HEX0, 7'h0E);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
